// File: rtl/alu_seq.sv
// Multi-cycle EX-stage ALU: single-cycle logic/arith ops plus iterative unsigned MUL/DIVU/REMU.
// Define ALU_MULDIV_EN to build the multiply/divide datapath; otherwise those codes are illegal.
module alu_seq #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] valor1,
    input  logic [WIDTH-1:0] valor2,
    input  logic [3:0]       ALUcontrol,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] ALUresult,
    output logic             zero,
    output logic             erro
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;
    localparam logic [3:0] OP_REMU = 4'b1010;

    // Reject configurations the iteration counter cannot cover.
    if (WIDTH < 8 || CNT_W < $clog2(WIDTH) + 1) begin : g_bad_params
        $fatal(1, "alu_seq: WIDTH must be >= 8 and CNT_W >= $clog2(WIDTH)+1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_DONE
`ifdef ALU_MULDIV_EN
        ,
        S_MUL,
        S_DIV
`endif
    } state_t;

    state_t           state;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;    // operand 1; multiplicand or dividend/quotient while iterating
    logic [WIDTH-1:0] b_q;    // operand 2; multiplier shift register or divisor

    logic [WIDTH-1:0] result_c;
    logic             erro_c;

`ifdef ALU_MULDIV_EN
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] rem;
    logic [WIDTH:0]   rem_sh_c;
    logic [WIDTH:0]   rem_diff_c;
    logic             q_bit_c;
    logic             last_iter_c;

    // One restoring-division step: shift in next dividend bit, try subtracting the divisor.
    always_comb begin
        rem_sh_c    = {rem, a_q[WIDTH-1]};
        rem_diff_c  = rem_sh_c - {1'b0, b_q};
        q_bit_c     = (rem_sh_c >= {1'b0, b_q});
        last_iter_c = (cnt == CNT_W'(WIDTH - 1));
    end
`endif

    // Final result selection from the latched opcode and operands.
    always_comb begin
        result_c = '0;
        erro_c   = 1'b0;
        case (op_q)
            OP_AND:  result_c = a_q & b_q;
            OP_OR:   result_c = a_q | b_q;
            OP_ADD:  result_c = a_q + b_q;
            OP_SUB:  result_c = a_q - b_q;
            OP_SLT:  result_c = {{(WIDTH - 1){1'b0}}, ($signed(a_q) < $signed(b_q))};
`ifdef ALU_MULDIV_EN
            OP_MUL:  result_c = acc;
            // Divide-by-zero skips iteration, so a_q still holds valor1 here.
            OP_DIVU: result_c = (b_q == '0) ? '1 : a_q;
            OP_REMU: result_c = (b_q == '0) ? a_q : rem;
`endif
            default: begin
                result_c = '0;
                erro_c   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            ready     <= 1'b1;
            done      <= 1'b0;
            ALUresult <= '0;
            zero      <= 1'b1;
            erro      <= 1'b0;
`ifdef ALU_MULDIV_EN
            cnt       <= '0;
            acc       <= '0;
            rem       <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                // DONE also accepts, giving one simple op every two cycles.
                S_IDLE, S_DONE: begin
                    ready <= 1'b1;
                    state <= S_IDLE;
                    if (start) begin
                        ready <= 1'b0;
                        op_q  <= ALUcontrol;
                        a_q   <= valor1;
                        b_q   <= valor2;
                        state <= S_EXEC;
`ifdef ALU_MULDIV_EN
                        cnt   <= '0;
                        acc   <= '0;
                        rem   <= '0;
                        if (ALUcontrol == OP_MUL) begin
                            state <= S_MUL;
                        end else if ((ALUcontrol == OP_DIVU || ALUcontrol == OP_REMU) &&
                                     valor2 != '0) begin
                            state <= S_DIV;
                        end
`endif
                    end
                end
                S_EXEC: begin
                    ALUresult <= result_c;
                    zero      <= (result_c == '0);
                    erro      <= erro_c;
                    done      <= 1'b1;
                    ready     <= 1'b1;
                    state     <= S_DONE;
                end
`ifdef ALU_MULDIV_EN
                S_MUL: begin
                    if (b_q[0]) begin
                        acc <= acc + a_q;
                    end
                    a_q <= a_q << 1;
                    b_q <= b_q >> 1;
                    if (last_iter_c) begin
                        state <= S_EXEC;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DIV: begin
                    rem <= q_bit_c ? rem_diff_c[WIDTH-1:0] : rem_sh_c[WIDTH-1:0];
                    a_q <= {a_q[WIDTH-2:0], q_bit_c};
                    if (last_iter_c) begin
                        state <= S_EXEC;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`endif
                default: begin
                    state <= S_IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=64); expectations follow the ALU_MULDIV_EN build.
module tb_alu_seq;

    localparam int unsigned W = 64;

`ifdef ALU_MULDIV_EN
    localparam int         LMD   = 65;
    localparam bit         E_MD  = 1'b0;
`else
    localparam int         LMD   = 1;
    localparam bit         E_MD  = 1'b1;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [W-1:0]  valor1;
    logic [W-1:0]  valor2;
    logic [3:0]    ALUcontrol;
    logic          ready;
    logic          done;
    logic [W-1:0]  ALUresult;
    logic          zero;
    logic          erro;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int acc_cyc  = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start),
        .valor1(valor1), .valor2(valor2), .ALUcontrol(ALUcontrol),
        .ready(ready), .done(done), .ALUresult(ALUresult), .zero(zero), .erro(erro)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation and check latency, result and flags at its done pulse.
    task automatic do_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] er, input logic ee,
                         input int lat, input bit poke);
        int i;
        logic [W-1:0] held;
        i = 0;
        while (ready !== 1'b1 && i < 200) begin
            @(posedge clk); #1; i++;
        end
        held = ALUresult;
        start = 1'b1; ALUcontrol = op; valor1 = a; valor2 = b;
        @(posedge clk); #1;
        acc_cyc = cyc;
        start = 1'b0; valor1 = ~a; valor2 = ~b; ALUcontrol = ~op;
        chk({tag, " ready_after_accept"}, W'(ready), W'(0));
        i = 0;
        while (done !== 1'b1 && i < 200) begin
            if (poke) begin
                start  = (i % 3 == 0);
                valor1 = W'($urandom);
            end
            @(posedge clk); #1; i++;
            if (poke && done !== 1'b1) begin
                chk({tag, " ready_busy"}, W'(ready), W'(0));
                chk({tag, " result_held"}, ALUresult, held);
            end
        end
        start = 1'b0;
        chk({tag, " latency"}, W'(i), W'(lat));
        chk({tag, " result"}, ALUresult, er);
        chk({tag, " zero"}, W'(zero), W'(er == '0));
        chk({tag, " erro"}, W'(erro), W'(ee));
        chk({tag, " ready_done"}, W'(ready), W'(1));
    endtask

    initial begin
        int a_sub;
        int dcount;
        reset = 1'b1; start = 1'b0; valor1 = '0; valor2 = '0; ALUcontrol = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst ready", W'(ready), W'(1));
        chk("rst done", W'(done), W'(0));
        chk("rst result", ALUresult, W'(0));
        chk("rst zero", W'(zero), W'(1));
        chk("rst erro", W'(erro), W'(0));
        reset = 1'b0;

        do_op("add", 4'b0010, W'(5), W'(7), W'(12), 1'b0, 1, 1'b0);
        do_op("sub", 4'b0110, W'(9), W'(9), W'(0), 1'b0, 1, 1'b0);
        a_sub = acc_cyc;
        chk("sub done_one_cycle", W'(done), W'(1));
        do_op("slt", 4'b0111, '1, W'(1), W'(1), 1'b0, 1, 1'b0);
        chk("b2b spacing", W'(acc_cyc - a_sub), W'(2));
        do_op("slt_rev", 4'b0111, W'(1), '1, W'(0), 1'b0, 1, 1'b0);
        do_op("and", 4'b0000, W'(16'hF0F0), W'(16'hFF00), W'(16'hF000), 1'b0, 1, 1'b0);
        do_op("or", 4'b0001, W'(16'hF0F0), W'(16'hFF00), W'(16'hFFF0), 1'b0, 1, 1'b0);
        do_op("add_wrap", 4'b0010, '1, W'(1), W'(0), 1'b0, 1, 1'b0);
        do_op("sub_wrap", 4'b0110, W'(0), W'(1), '1, 1'b0, 1, 1'b0);

`ifdef ALU_MULDIV_EN
        do_op("mul", 4'b1000, 64'hFFFF_FFFF, 64'h1_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, LMD, 1'b1);
        do_op("divu", 4'b1001, W'(100), W'(7), W'(14), 1'b0, LMD, 1'b0);
        do_op("remu", 4'b1010, W'(100), W'(7), W'(2), 1'b0, LMD, 1'b0);
        do_op("divu0", 4'b1001, W'(5), W'(0), '1, 1'b0, 1, 1'b0);
        do_op("remu0", 4'b1010, W'(42), W'(0), W'(42), 1'b0, 1, 1'b0);
`else
        do_op("mul_off", 4'b1000, 64'hFFFF_FFFF, 64'h1_0000_0001, W'(0), E_MD, LMD, 1'b0);
        do_op("divu_off", 4'b1001, W'(100), W'(7), W'(0), E_MD, LMD, 1'b0);
        do_op("remu_off", 4'b1010, W'(42), W'(0), W'(0), E_MD, LMD, 1'b0);
`endif
        do_op("illegal_f", 4'b1111, W'(3), W'(4), W'(0), 1'b1, 1, 1'b0);
        do_op("illegal_3", 4'b0011, W'(3), W'(4), W'(0), 1'b1, 1, 1'b0);
        do_op("add_pre", 4'b0010, W'(30), W'(12), W'(42), 1'b0, 1, 1'b0);

        // Reset ten cycles into a DIVU.
        start = 1'b1; ALUcontrol = 4'b1001; valor1 = W'(1000); valor2 = W'(3);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst ready", W'(ready), W'(1));
        chk("midrst done", W'(done), W'(0));
        chk("midrst result", ALUresult, W'(0));
        chk("midrst zero", W'(zero), W'(1));
        reset = 1'b0;
        dcount = 0;
        repeat (70) begin
            @(posedge clk); #1;
            if (done === 1'b1) dcount++;
        end
        chk("midrst no_done", W'(dcount), W'(0));
        do_op("add_after", 4'b0010, W'(1), W'(1), W'(2), 1'b0, 1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
